// File: rtl/fetch_unit.sv
// Fetch stage: PC, in-flight read tracking for a 1-cycle registered instruction memory, IF/ID register.
// Optional macro HALT_DETECT_EN enables stopping fetch on HALT_WORD.
module fetch_unit #(
    parameter int ADDR_WIDTH  = 12,
    parameter int INSTR_WIDTH = 19,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = {ADDR_WIDTH{1'b0}}
`ifdef HALT_DETECT_EN
    ,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD = {INSTR_WIDTH{1'b1}}
`endif
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    input  logic [INSTR_WIDTH-1:0] mem_instruction,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_target,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0]  id_pc,
    output logic [ADDR_WIDTH-1:0]  id_pc_next,
    output logic                   id_valid,
    output logic                   halted
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  f2_pc_q, f2_pc_d;
    logic                   f2_valid_q, f2_valid_d;
    logic [INSTR_WIDTH-1:0] id_instr_q, id_instr_d;
    logic [ADDR_WIDTH-1:0]  id_pc_q, id_pc_d;
    logic [ADDR_WIDTH-1:0]  id_pc_next_q, id_pc_next_d;
    logic                   id_valid_q, id_valid_d;
    logic                   halted_q, halted_d;
    logic                   halt_hit_s;

`ifdef HALT_DETECT_EN
    assign halt_hit_s = f2_valid_q && (mem_instruction == HALT_WORD);
`else
    assign halt_hit_s = 1'b0;
`endif

    // Address to memory: re-read the in-flight word while held so its data stays stable.
    always_comb begin
        mem_address = pc_q;
        if (halted_q) begin
            mem_address = f2_pc_q;
        end else if (redirect) begin
            mem_address = redirect_target;
        end else if (stall) begin
            mem_address = f2_pc_q;
        end else begin
            mem_address = pc_q;
        end
    end

    // Next-state: halt freezes everything, redirect beats stall, stall holds all state.
    always_comb begin
        pc_d         = pc_q;
        f2_pc_d      = f2_pc_q;
        f2_valid_d   = f2_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_pc_next_d = id_pc_next_q;
        id_valid_d   = id_valid_q;
        halted_d     = halted_q;
        if (halted_q) begin
            id_valid_d = 1'b0;
        end else if (redirect) begin
            f2_pc_d    = redirect_target;
            f2_valid_d = 1'b1;
            pc_d       = redirect_target + PC_ONE;
            id_valid_d = 1'b0;
        end else if (stall) begin
            id_valid_d = id_valid_q;
        end else begin
            f2_pc_d      = pc_q;
            f2_valid_d   = 1'b1;
            pc_d         = pc_q + PC_ONE;
            id_instr_d   = mem_instruction;
            id_pc_d      = f2_pc_q;
            id_pc_next_d = f2_pc_q + PC_ONE;
            id_valid_d   = f2_valid_q;
            if (halt_hit_s) begin
                halted_d   = 1'b1;
                f2_valid_d = 1'b0;
            end else begin
                halted_d   = 1'b0;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            f2_pc_q      <= {ADDR_WIDTH{1'b0}};
            f2_valid_q   <= 1'b0;
            id_instr_q   <= {INSTR_WIDTH{1'b0}};
            id_pc_q      <= {ADDR_WIDTH{1'b0}};
            id_pc_next_q <= {ADDR_WIDTH{1'b0}};
            id_valid_q   <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            f2_pc_q      <= f2_pc_d;
            f2_valid_q   <= f2_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_pc_next_q <= id_pc_next_d;
            id_valid_q   <= id_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign id_instr   = id_instr_q;
    assign id_pc      = id_pc_q;
    assign id_pc_next = id_pc_next_q;
    assign id_valid   = id_valid_q;
    assign halted     = halted_q;

endmodule
